l1_cache_ctrl_wb: RTL
=====================

Name: l1_cache_ctrl_wb

Overview:
Parametrised, self-contained L1 cache controller with write-back and write-allocate policies. It holds its own tag, data, valid, dirty and LRU storage in flops. It services one CPU request at a time. On a miss it writes back a dirty victim and refills the line from the next level (L2 or memory) over a valid/ready request channel with a separate response channel. It sits between the CPU request interface and the L2 side, and replaces the bare controller state machine with a working hit/miss datapath.

Parameters:
ADDR_WIDTH, 32, CPU byte address width
DATA_WIDTH, 32, word width; line = one word; power of 2, >= 8
NUM_SETS, 16, sets; power of 2, >= 2
NUM_WAYS, 2, associativity; legal values 1 or 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller can accept; high only in IDLE
cpu_req_op  in  1  0 = read, 1 = write
cpu_req_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
cpu_write_data  in  DATA_WIDTH  write data
cpu_resp_valid  out  1  one-cycle response pulse; no backpressure
cpu_read_data  out  DATA_WIDTH  read data (reads) or written data (writes)
mem_req_valid  out  1  next-level request
mem_req_ready  in  1  next level accepts request
mem_req_we  out  1  1 = writeback (posted, no response), 0 = refill read
mem_req_addr  out  ADDR_WIDTH  line address; offset bits zero
mem_req_wdata  out  DATA_WIDTH  victim data
mem_resp_valid  in  1  refill data valid
mem_resp_rdata  in  DATA_WIDTH  refill data

Behaviour:
- Reset: synchronous, active-high. Clears all valid, dirty and LRU bits. FSM goes to IDLE.
- Output values during reset: cpu_req_ready=1, cpu_resp_valid=0, mem_req_valid=0; all data and address outputs 0.
- Reset asserted mid-operation abandons the transaction. A late mem_resp_valid arriving in IDLE is ignored.
- Address split: offset = log2(DATA_WIDTH/8) bits; index = next log2(NUM_SETS) bits; tag = remaining bits.
- Request accept: in IDLE, a request is accepted when cpu_req_valid && cpu_req_ready. Address, op and write data are registered on acceptance.
- Hit latency: accept at cycle N -> LOOKUP at N+1 -> cpu_resp_valid at N+2.
- LOOKUP: compare the tag against all valid ways of the indexed set.
- Hit, read: return the line data.
- Hit, write: overwrite the line and set dirty=1.
- Any hit: LRU points to the other way. Go to RESPOND.
- Miss, victim selection: the first invalid way (way 0 has priority). If none is invalid, the LRU way. With NUM_WAYS=1 the victim is always way 0.
- Miss with valid and dirty victim: go to WRITEBACK.
- Miss otherwise: go to REFILL_REQ.
- WRITEBACK: mem_req_valid=1, we=1, addr = {victim tag, index, 0}, wdata = victim data. Hold all fields stable until mem_req_ready, then go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, we=0, addr = {tag, index, 0}. Hold until mem_req_ready, then go to REFILL_WAIT.
- REFILL_WAIT: wait any number of cycles for mem_resp_valid, then install the line:
  - valid=1 and tag written.
  - data = cpu_write_data for a write, mem_resp_rdata for a read.
  - dirty = op. LRU points away from the filled way.
  - Go to RESPOND.
- RESPOND: cpu_resp_valid=1 for exactly one cycle, then go to IDLE. cpu_req_ready returns to 1 the following cycle.
- A new request is never accepted while a transaction is outstanding.
- mem_resp_valid outside REFILL_WAIT is ignored.

Optional Feature:
L1_CACHE_STATS_EN:
- When defined, adds three 32-bit outputs: stat_hits, stat_misses, stat_writebacks.
- stat_hits increments on a LOOKUP hit. stat_misses increments on a LOOKUP miss. stat_writebacks increments on a WRITEBACK handshake.
- All three saturate at 0xFFFF_FFFF and are cleared by reset.
- When undefined, these ports and counters do not exist.

Test Plan:
All scenarios use ADDR_WIDTH=32, DATA_WIDTH=32, NUM_SETS=16, NUM_WAYS=2.
- Cold read miss: after reset, read 0x40 -> single mem req with we=0, addr=0x40. Drive mem_resp_rdata=0xDEADBEEF -> cpu_read_data=0xDEADBEEF. Re-read 0x40 -> hit, response 2 cycles after accept, no mem_req_valid.
- Write hit: write 0x12345678 to cached 0x40 -> no mem traffic. Read 0x40 -> 0x12345678.
- LRU and dirty eviction, all in set 0, in this order:
  - write 0x000 (miss, line becomes dirty);
  - read 0x040 (miss);
  - read 0x000 (hit);
  - read 0x080 -> evicts 0x040 with no writeback;
  - read 0x0C0 -> writeback addr=0x000 with the earlier write data, then refill addr=0x0C0.
- Backpressure: hold mem_req_ready=0 for 5 cycles during WRITEBACK and during REFILL_REQ -> mem_req_valid, addr, we and wdata stay stable; exactly one handshake each.
- Reset mid-refill: assert reset in REFILL_WAIT, then send mem_resp_valid in IDLE -> ignored, cpu_resp_valid stays 0. Read 0x40 -> misses again.
- With L1_CACHE_STATS_EN: after the eviction scenario -> stat_hits=1, stat_misses=4, stat_writebacks=1.

Source files
------------

// File: rtl/l1_cache_ctrl_wb.sv
// L1 cache controller, one word per line, 1- or 2-way, write-back + write-allocate.
// Define L1_CACHE_STATS_EN to add saturating hit/miss/writeback counters.
module l1_cache_ctrl_wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_op,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_writebacks
`endif
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;
  state_t state, state_nxt;

  logic [NUM_WAYS-1:0]   valid [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty [NUM_SETS];
  logic [NUM_SETS-1:0]   lru;  // per set: the way to evict when both are valid
  logic [TAG_W-1:0]      tags  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] lines [NUM_SETS][NUM_WAYS];

  logic                  op_r, victim_r;
  logic [TAG_W-1:0]      tag_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] wdata_r, rsp_r;
  logic                  hit, hit_way, victim, victim_dirty, fill;
  logic [ADDR_WIDTH-1:0] unused_addr;

  assign unused_addr  = cpu_req_addr;  // offset bits are intentionally dropped
  assign fill         = (state == REFILL_WAIT) && mem_resp_valid;
  assign victim_dirty = valid[idx_r][victim] && dirty[idx_r][victim];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid[idx_r][w] && tags[idx_r][w] == tag_r) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    // lowest-numbered invalid way wins, otherwise the LRU way
    victim = (NUM_WAYS == 2) ? lru[idx_r] : 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid[idx_r][w]) victim = 1'(w);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cpu_req_ready  = reset || (state == IDLE);
    cpu_resp_valid = 1'b0;
    cpu_read_data  = reset ? '0 : rsp_r;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    unique case (state)
      IDLE:        if (cpu_req_valid) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit)               state_nxt = RESPOND;
        else if (victim_dirty) state_nxt = WRITEBACK;
        else                   state_nxt = REFILL_REQ;
      end
      WRITEBACK: begin
        mem_req_valid = !reset;
        mem_req_we    = !reset;
        mem_req_addr  = reset ? '0 : ADDR_WIDTH'({tags[idx_r][victim_r], idx_r}) << OFF_W;
        mem_req_wdata = reset ? '0 : lines[idx_r][victim_r];
        if (mem_req_ready) state_nxt = REFILL_REQ;
      end
      REFILL_REQ: begin
        mem_req_valid = !reset;
        mem_req_addr  = reset ? '0 : ADDR_WIDTH'({tag_r, idx_r}) << OFF_W;
        if (mem_req_ready) state_nxt = REFILL_WAIT;
      end
      REFILL_WAIT: if (mem_resp_valid) state_nxt = RESPOND;
      RESPOND: begin
        cpu_resp_valid = !reset;
        state_nxt      = IDLE;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
      lru      <= '0;
      op_r     <= 1'b0;
      victim_r <= 1'b0;
      tag_r    <= '0;
      idx_r    <= '0;
      wdata_r  <= '0;
      rsp_r    <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid) begin
        op_r    <= cpu_req_op;
        tag_r   <= cpu_req_addr[ADDR_WIDTH-1 -: TAG_W];
        idx_r   <= cpu_req_addr[OFF_W +: IDX_W];
        wdata_r <= cpu_write_data;
      end
      if (state == LOOKUP) begin
        victim_r <= victim;
        if (hit) begin
          rsp_r <= op_r ? wdata_r : lines[idx_r][hit_way];
          if (op_r) dirty[idx_r][hit_way] <= 1'b1;
          if (NUM_WAYS == 2) lru[idx_r] <= ~hit_way;
        end
      end
      if (fill) begin
        valid[idx_r][victim_r] <= 1'b1;
        dirty[idx_r][victim_r] <= op_r;
        if (NUM_WAYS == 2) lru[idx_r] <= ~victim_r;
        rsp_r <= op_r ? wdata_r : mem_resp_rdata;
      end
    end
  end

  // tag/data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOOKUP && hit && op_r) lines[idx_r][hit_way] <= wdata_r;
      if (fill) begin
        tags[idx_r][victim_r]  <= tag_r;
        lines[idx_r][victim_r] <= op_r ? wdata_r : mem_resp_rdata;
      end
    end
  end

`ifdef L1_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == LOOKUP && hit && stat_hits != '1)    stat_hits   <= stat_hits + 32'd1;
      if (state == LOOKUP && !hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      if (state == WRITEBACK && mem_req_ready && stat_writebacks != '1)
        stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif
endmodule
